// File: rtl/riscv_pkg.sv
`default_nettype none
// riscv_pkg -- constants and response record shared by the instruction-fetch path.
// Rev 1.0
package riscv_pkg;

  localparam logic [31:0] NOP_WORD       = 32'h0000_0013;
  localparam int          RSP_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  // A fetch is in error when misaligned or beyond the 2^aw-word store.
  function automatic logic fetch_err(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// rsp_fifo -- small power-of-two response queue, combinational head, pointers cleared by reset.
// Rev 1.0
module rsp_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = RSP_FIFO_DEPTH,
  parameter int WIDTH = RSP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             full;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// imem_responder -- loadable instruction store answering in-order fetches through a fixed pipeline and response queue.
// Rev 1.0
module imem_responder
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = riscv_pkg::NOP_WORD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  output logic                           req_ready,
  output logic                           rsp_valid,
  output logic [31:0]                    rsp_data,
  output logic                           rsp_err,
  input  logic                           rsp_ready,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   store [DEPTH_WORDS];
  logic [2:0]    outstanding;
  logic          accept;
  logic          pop;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  rsp_t          rd_rsp;
  logic          push_vld;
  rsp_t          push_rsp;
  logic [RSP_W-1:0] fifo_head;
  logic          fifo_empty;
  rsp_t          head;

  // Outstanding covers pipeline plus queue, so capping it at the queue depth prevents overflow.
  assign req_ready = reset && (outstanding < 3'd4);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= 3'd0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && reset) store[ld_addr] <= ld_data;
  end

  // Asynchronous read in the acceptance cycle sees the pre-write word on a same-cycle load.
  assign rd_idx = req_addr[AW+1:2];
  assign rd_err = fetch_err(req_addr, AW);

  always_comb begin
    rd_rsp.err  = rd_err;
    rd_rsp.data = rd_err ? NOP_WORD : store[rd_idx];
  end

  // The acceptance cycle is the first pipeline stage; LATENCY-1 registers follow before the queue.
  if (LATENCY <= 1) begin : g_lat1
    assign push_vld = accept;
    assign push_rsp = rd_rsp;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;

    logic [NS-1:0] vld;
    rsp_t          dat [NS];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld <= '0;
      end else begin
        vld[0] <= accept;
        for (int i = 1; i < NS; i++) vld[i] <= vld[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat[0] <= rd_rsp;
      for (int i = 1; i < NS; i++) dat[i] <= dat[i-1];
    end

    assign push_vld = vld[NS-1];
    assign push_rsp = dat[NS-1];
  end

  rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_vld),
    .wr_data (push_rsp),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );

  assign head      = fifo_head;
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_valid ? head.data : 32'd0;
  assign rsp_err   = rsp_valid ? head.err  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// tb_imem_responder -- scoreboard bench for imem_responder (DEPTH_WORDS=256, LATENCY=2).
// Rev 1.0
module tb_imem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int AW          = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          rsp_ready;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  imem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (2),
    .NOP_WORD    (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  int          n_vec   = 0;
  int          n_err   = 0;
  int          cyc     = 0;
  int          exp_out = 0;
  exp_t        sb[$];
  logic [31:0] mdl [DEPTH_WORDS];
  bit          last_acc;
  bit          lat_arm;
  int          lat_acc_c;
  int          lat_rsp_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH_WORDS)) begin
      e.data = 32'h0000_0013;
      e.err  = 1'b1;
    end else begin
      e.data = mdl[a[AW+1:2]];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // One clock: observe at the falling edge, update the model, then step past the rising edge.
  task automatic cycle();
    bit acc;
    bit pp;
    @(negedge clk);
    chk("req_ready", req_ready, reset && (exp_out < 4));
    acc = req_valid && req_ready;
    pp  = 1'b0;
    if (lat_arm && acc && lat_acc_c < 0) lat_acc_c = cyc;
    if (lat_arm && rsp_valid && lat_rsp_c < 0) lat_rsp_c = cyc;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_valid_unexpected", rsp_valid, 0);
      end else begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_err", rsp_err, sb[0].err);
        if (rsp_ready) begin
          void'(sb.pop_front());
          pp = 1'b1;
        end
      end
    end
    if (acc) sb.push_back(model_fetch(req_addr));
    if (ld_en && reset) mdl[ld_addr] = ld_data;
    exp_out  = exp_out + int'(acc) - int'(pp);
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    ld_en   = 1'b1;
    ld_addr = AW'(idx);
    ld_data = val;
    cycle();
    ld_en   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_addr  = a;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    chk("fetch_accept", last_acc, 1);
  endtask

  task automatic drain();
    int n;
    n         = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || exp_out != 0) && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int acc_n;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    lat_arm   = 1'b0;
    lat_acc_c = -1;
    lat_rsp_c = -1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b1;

    load(0, 32'h0050_0093);
    load(1, 32'h0030_0113);
    load(2, 32'h0020_81B3);
    load(3, 32'h0000_0013);
    load(5, 32'h1111_1111);
    load(255, 32'hCAFE_F00D);

    // Back-to-back fetches with the consumer always ready.
    rsp_ready = 1'b1;
    lat_arm   = 1'b1;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    drain();
    lat_arm = 1'b0;
    chk("first_latency", lat_rsp_c - lat_acc_c, 2);

    // Misaligned, just out of range, and the last valid word.
    fetch(32'h2);
    fetch(32'h400);
    fetch(32'h3FC);
    drain();

    // Stalled consumer: only four requests fit.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    acc_n     = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'((acc_n % 4) * 4);
      cycle();
      if (last_acc) acc_n++;
    end
    chk("stall_accepts", acc_n, 4);
    chk("stall_req_ready", req_ready, 0);

    // Pop and request together at the cap: accepted one cycle later.
    rsp_ready = 1'b1;
    req_addr  = 32'h8;
    cycle();
    chk("full_pop_no_accept", last_acc, 0);
    cycle();
    chk("next_cycle_accept", last_acc, 1);
    drain();
    chk("ready_after_drain", req_ready, 1);

    // Reset with responses in flight; a load during reset must be dropped.
    rsp_ready = 1'b0;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    sb.delete();
    exp_out = 0;
    ld_en   = 1'b1;
    ld_addr = '0;
    ld_data = 32'hBAD0_BAD0;
    cycle();
    cycle();
    ld_en     = 1'b0;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) cycle();
    chk("post_rst_ready", req_ready, 1);
    fetch(32'h0);
    drain();

    // Same-cycle load and fetch of word 5 returns the old word; the next fetch sees the new one.
    ld_en   = 1'b1;
    ld_addr = 8'd5;
    ld_data = 32'hDEAD_BEEF;
    fetch(32'h14);
    ld_en = 1'b0;
    fetch(32'h14);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
